// File: rtl/mem_wb_pipe_reg_pkg.sv
// MEM->WB stage register shared definitions.
// Stage-action encoding shared by every pipeline stage register.
package mem_wb_pipe_reg_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

  localparam reg_data_t ZERO_WORD = '0;

  localparam logic [1:0] ACT_ADVANCE = 2'd0;
  localparam logic [1:0] ACT_HOLD    = 2'd1;
  localparam logic [1:0] ACT_BUBBLE  = 2'd2;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v
  );
    return (v == CNT_MAX) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mem_wb_pipe_reg_pipe_stall_ctl.sv
// Stage-action decoder: stall vector + flush -> advance/hold/bubble.
// Generic over stall width and stage position so every stage register can reuse it.
module pipe_stall_ctl
  import mem_wb_pipe_reg_pkg::*;
#(
  parameter int STALL_W   = 6,
  parameter int STAGE_IDX = 4
) (
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  output logic [1:0]         act
);

  logic own;
  logic down;

  assign own = stall[STAGE_IDX];

  // The last stage has no downstream stall bit.
  generate
    if (STAGE_IDX < STALL_W - 1) begin : g_down
      assign down = stall[STAGE_IDX+1];
    end else begin : g_last
      assign down = 1'b0;
    end
  endgenerate

  logic unused_stall;
  assign unused_stall = ^stall;

  always_comb begin
    act = ACT_ADVANCE;
    unique case (1'b1)
      own & down:    act = ACT_HOLD;
      own & ~down:   act = ACT_BUBBLE;
      ~own & flush:  act = ACT_BUBBLE;
      ~own & ~flush: act = ACT_ADVANCE;
      default:       act = ACT_ADVANCE;
    endcase
  end

endmodule

// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB pipeline register with multi-channel write filtering and retire count.
// Optional HI/LO write channel enabled by defining MEM_WB_HILO_EN.
module mem_wb_pipe_reg
  import mem_wb_pipe_reg_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int NUM_WR     = 2,
  parameter int STALL_W    = 6,
  parameter int STAGE_IDX  = 4,
  parameter int ZERO_SUPPR = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [STALL_W-1:0]       stall,
  input  logic                     flush,
  input  logic                     valid_i,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
  input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
`ifdef MEM_WB_HILO_EN
  input  logic                     hilo_we_i,
  input  logic [DATA_W-1:0]        hi_i,
  input  logic [DATA_W-1:0]        lo_i,
  output logic                     hilo_we_o,
  output logic [DATA_W-1:0]        hi_o,
  output logic [DATA_W-1:0]        lo_o,
`endif
  output logic                     valid_o,
  output logic [NUM_WR-1:0]        wr_en_o,
  output logic [NUM_WR*ADDR_W-1:0] wr_addr_o,
  output logic [NUM_WR*DATA_W-1:0] wr_data_o,
  output logic [31:0]              retire_cnt_o
);

  logic [1:0] act;

  pipe_stall_ctl #(
    .STALL_W   (STALL_W),
    .STAGE_IDX (STAGE_IDX)
  ) u_ctl (
    .stall (stall),
    .flush (flush),
    .act   (act)
  );

  logic [NUM_WR-1:0] en_raw;
  logic [NUM_WR-1:0] en_flt;

  // Highest-index channel wins when two enabled channels target one register.
  generate
    for (genvar k = 0; k < NUM_WR; k++) begin : g_ch
      logic [ADDR_W-1:0] a_k;
      logic              hit;

      assign a_k = wr_addr_i[k*ADDR_W +: ADDR_W];
      assign en_raw[k] = wr_en_i[k] & valid_i
                       & ~((ZERO_SUPPR != 0) && (a_k == '0));

      always_comb begin
        hit = 1'b0;
        for (int j = k + 1; j < NUM_WR; j++) begin
          if (en_raw[j] && (wr_addr_i[j*ADDR_W +: ADDR_W] == a_k))
            hit = 1'b1;
        end
      end

      assign en_flt[k] = en_raw[k] & ~hit;
    end
  endgenerate

  logic [31:0] retire_cnt_q;
  assign retire_cnt_o = retire_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o      <= DISABLE;
      wr_en_o      <= '0;
      wr_addr_o    <= '0;
      wr_data_o    <= '0;
      retire_cnt_q <= '0;
    end else begin
      case (act)
        ACT_ADVANCE: begin
          valid_o   <= valid_i;
          wr_en_o   <= en_flt;
          wr_addr_o <= wr_addr_i;
          wr_data_o <= wr_data_i;
          if (valid_i)
            retire_cnt_q <= sat_inc(retire_cnt_q);
        end
        ACT_BUBBLE: begin
          valid_o   <= DISABLE;
          wr_en_o   <= '0;
          wr_addr_o <= '0;
          wr_data_o <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_WB_HILO_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hilo_we_o <= DISABLE;
      hi_o      <= '0;
      lo_o      <= '0;
    end else begin
      case (act)
        ACT_ADVANCE: begin
          hilo_we_o <= hilo_we_i & valid_i;
          hi_o      <= hi_i;
          lo_o      <= lo_i;
        end
        ACT_BUBBLE: begin
          hilo_we_o <= DISABLE;
          hi_o      <= '0;
          lo_o      <= '0;
        end
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Self-checking bench for mem_wb_pipe_reg (default parameters).
// Reference model applies the stage rules directly on plain variables.
module tb_mem_wb_pipe_reg;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NW = 2;
  localparam int SW = 6;
  localparam int SI = 4;
  localparam int VW = 1 + NW + NW*AW + NW*DW + 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [SW-1:0]    stall;
  logic             flush;
  logic             valid_i;
  logic [NW-1:0]    wr_en_i;
  logic [NW*AW-1:0] wr_addr_i;
  logic [NW*DW-1:0] wr_data_i;
  logic             valid_o;
  logic [NW-1:0]    wr_en_o;
  logic [NW*AW-1:0] wr_addr_o;
  logic [NW*DW-1:0] wr_data_o;
  logic [31:0]      retire_cnt_o;
`ifdef MEM_WB_HILO_EN
  logic             hilo_we_i = 1'b0;
  logic [DW-1:0]    hi_i = '0;
  logic [DW-1:0]    lo_i = '0;
  logic             hilo_we_o;
  logic [DW-1:0]    hi_o;
  logic [DW-1:0]    lo_o;
`endif

  mem_wb_pipe_reg dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .valid_i      (valid_i),
    .wr_en_i      (wr_en_i),
    .wr_addr_i    (wr_addr_i),
    .wr_data_i    (wr_data_i),
`ifdef MEM_WB_HILO_EN
    .hilo_we_i    (hilo_we_i),
    .hi_i         (hi_i),
    .lo_i         (lo_i),
    .hilo_we_o    (hilo_we_o),
    .hi_o         (hi_o),
    .lo_o         (lo_o),
`endif
    .valid_o      (valid_o),
    .wr_en_o      (wr_en_o),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o),
    .retire_cnt_o (retire_cnt_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic             m_valid;
  logic [NW-1:0]    m_en;
  logic [NW*AW-1:0] m_addr;
  logic [NW*DW-1:0] m_data;
  logic [31:0]      m_cnt;

  wire [VW-1:0] dut_vec = {valid_o, wr_en_o, wr_addr_o, wr_data_o, retire_cnt_o};

  function automatic logic [VW-1:0] exp_vec();
    return {m_valid, m_en, m_addr, m_data, m_cnt};
  endfunction

  task automatic model_step();
    logic [AW-1:0] ak;
    logic [AW-1:0] aj;
    logic [NW-1:0] raw;
    if (rst) begin
      m_valid = 0; m_en = 0; m_addr = 0; m_data = 0; m_cnt = 0;
    end else if (stall[SI] && stall[SI+1]) begin
      // hold
    end else if (stall[SI] || flush) begin
      m_valid = 0; m_en = 0; m_addr = 0; m_data = 0;
    end else begin
      m_valid = valid_i;
      m_addr  = wr_addr_i;
      m_data  = wr_data_i;
      for (int k = 0; k < NW; k++) begin
        ak = wr_addr_i[k*AW +: AW];
        raw[k] = wr_en_i[k] && valid_i && (ak != 0);
      end
      for (int k = 0; k < NW; k++) begin
        ak = wr_addr_i[k*AW +: AW];
        m_en[k] = raw[k];
        for (int j = k + 1; j < NW; j++) begin
          aj = wr_addr_i[j*AW +: AW];
          if (raw[j] && aj == ak) m_en[k] = 0;
        end
      end
      if (valid_i && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end
  endtask

  task automatic drive(input logic v, input logic [NW-1:0] en,
                       input logic [NW*AW-1:0] a, input logic [NW*DW-1:0] d);
    valid_i = v; wr_en_i = en; wr_addr_i = a; wr_data_i = d;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    stall = '0; flush = 0;
    drive(1, 2'b11, {5'd9, 5'd4}, {32'h1234_5678, 32'h9ABC_DEF0});
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if (valid_o !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%0h exp=0", valid_o);
    end
    checks++;
    if (retire_cnt_o !== 32'd0) begin
      failures++; $display("FAIL reset_cnt got=%0h exp=0", retire_cnt_o);
    end
    checks++;
    if (dut_vec !== exp_vec()) begin
      failures++; $display("FAIL reset_all got=%h exp=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_advance();
    stall = '0; flush = 0;
    drive(1, 2'b01, {5'd0, 5'd3}, {32'h0, 32'hDEAD_BEEF});
    tick();
    checks++;
    if (wr_en_o !== 2'b01 || wr_addr_o[4:0] !== 5'd3 ||
        wr_data_o[31:0] !== 32'hDEAD_BEEF || valid_o !== 1'b1) begin
      failures++;
      $display("FAIL advance got en=%b a=%0d d=%h v=%b exp en=01 a=3 d=deadbeef v=1",
               wr_en_o, wr_addr_o[4:0], wr_data_o[31:0], valid_o);
    end
    checks++;
    if (retire_cnt_o !== 32'd1) begin
      failures++; $display("FAIL advance_cnt got=%0d exp=1", retire_cnt_o);
    end
  endtask

  task automatic test_stall();
    logic [VW-1:0] snap;
    snap = exp_vec();
    stall = 6'b110000;
    for (int i = 0; i < 3; i++) begin
      drive(1, 2'b11, {5'd20 + 5'(i), 5'd11}, {32'hAAAA_0000 + 32'(i), 32'h5555});
      tick();
      checks++;
      if (dut_vec !== snap) begin
        failures++; $display("FAIL stall_hold%0d got=%h exp=%h", i, dut_vec, snap);
      end
    end
    stall = 6'b010000;
    tick();
    checks++;
    if (valid_o !== 1'b0 || wr_en_o !== 2'b00 || retire_cnt_o !== 32'd1) begin
      failures++;
      $display("FAIL stall_bubble got v=%b en=%b cnt=%0d exp v=0 en=00 cnt=1",
               valid_o, wr_en_o, retire_cnt_o);
    end
    stall = '0;
  endtask

  task automatic test_flush();
    logic [VW-1:0] snap;
    stall = '0; flush = 0;
    drive(1, 2'b10, {5'd6, 5'd2}, {32'h0BAD_F00D, 32'h1});
    tick();
    flush = 1;
    drive(1, 2'b11, {5'd8, 5'd9}, {32'h2, 32'h3});
    tick();
    checks++;
    if (valid_o !== 1'b0 || wr_en_o !== 2'b00 || wr_data_o !== '0 ||
        retire_cnt_o !== 32'd2) begin
      failures++;
      $display("FAIL flush_bubble got v=%b en=%b cnt=%0d exp v=0 en=00 cnt=2",
               valid_o, wr_en_o, retire_cnt_o);
    end
    flush = 0;
    drive(1, 2'b01, {5'd0, 5'd12}, {32'h0, 32'hCAFE});
    tick();
    snap = exp_vec();
    flush = 1; stall = 6'b110000;
    drive(1, 2'b11, {5'd1, 5'd2}, {32'h7, 32'h8});
    tick();
    checks++;
    if (dut_vec !== snap || valid_o !== 1'b1) begin
      failures++; $display("FAIL flush_hold got=%h exp=%h", dut_vec, snap);
    end
    flush = 0; stall = '0;
  endtask

  task automatic test_filter();
    drive(1, 2'b11, {5'd7, 5'd7}, {32'h11, 32'h22});
    tick();
    checks++;
    if (wr_en_o !== 2'b10 || wr_addr_o !== {5'd7, 5'd7}) begin
      failures++; $display("FAIL filter_collision got=%b exp=10", wr_en_o);
    end
    drive(1, 2'b11, {5'd0, 5'd5}, {32'h33, 32'h44});
    tick();
    checks++;
    if (wr_en_o !== 2'b01 || wr_data_o !== {32'h33, 32'h44}) begin
      failures++; $display("FAIL filter_zero got=%b exp=01", wr_en_o);
    end
    drive(0, 2'b11, {5'd14, 5'd15}, {32'h55, 32'h66});
    tick();
    checks++;
    if (valid_o !== 1'b0 || wr_en_o !== 2'b00 ||
        wr_addr_o !== {5'd14, 5'd15} || wr_data_o !== {32'h55, 32'h66}) begin
      failures++;
      $display("FAIL filter_invalid got v=%b en=%b a=%h exp v=0 en=00 a=%h",
               valid_o, wr_en_o, wr_addr_o, {5'd14, 5'd15});
    end
    checks++;
    if (dut_vec !== exp_vec()) begin
      failures++; $display("FAIL filter_model got=%h exp=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 63) == 0);
      stall = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 4'($urandom)};
      flush = ($urandom_range(0, 7) == 0);
      drive(1'($urandom), 2'($urandom),
            {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))},
            {$urandom, $urandom});
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++; $display("FAIL random%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
    end
    rst = 0; stall = '0; flush = 0;
  endtask

  task automatic test_saturation();
    force dut.retire_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.retire_cnt_q;
    m_cnt = 32'hFFFF_FFFE;
    checks++;
    if (retire_cnt_o !== 32'hFFFF_FFFE) begin
      failures++; $display("FAIL sat_preload got=%h exp=fffffffe", retire_cnt_o);
    end
    stall = '0; flush = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 2'b01, {5'd1, 5'd2}, {32'h0, 32'(i)});
      tick();
      checks++;
      if (retire_cnt_o !== 32'hFFFF_FFFF || retire_cnt_o !== m_cnt) begin
        failures++; $display("FAIL sat%0d got=%h exp=ffffffff", i, retire_cnt_o);
      end
    end
  endtask

  initial begin
    rst = 1; stall = '0; flush = 0;
    drive(0, '0, '0, '0);
    m_valid = 0; m_en = 0; m_addr = 0; m_data = 0; m_cnt = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_advance();
    test_stall();
    test_flush();
    test_filter();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
